// File: rtl/sc_useq.sv
// Microsequencer: owns the microprogram counter, picks the next microaddress from
// the MIR COND/JMP_ADDR fields, flags and IR decode, and stalls on memory microinstructions.
module sc_useq #(
  parameter int              ADDR_WIDTH  = 11,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter logic [7:0]      MEM_TIMEOUT = 8'd255
) (
  input  logic                  SC_uSeq_CLOCK_50,
  input  logic                  SC_uSeq_Reset_InLow,
  input  logic [2:0]            SC_uSeq_COND_In,
  input  logic [ADDR_WIDTH-1:0] SC_uSeq_JMPADDR_In,
  input  logic                  SC_uSeq_RD_In,
  input  logic                  SC_uSeq_WR_In,
  input  logic                  SC_uSeq_N_In,
  input  logic                  SC_uSeq_Z_In,
  input  logic                  SC_uSeq_V_In,
  input  logic                  SC_uSeq_C_In,
  input  logic [1:0]            SC_uSeq_IROP_In,
  input  logic [5:0]            SC_uSeq_IROP3_In,
  input  logic                  SC_uSeq_IR13_In,
  input  logic                  SC_uSeq_MemReady_InHigh,
  output logic [ADDR_WIDTH-1:0] SC_uSeq_CSAddr_Out,
  output logic                  SC_uSeq_MIRWrite_OutHigh,
  output logic                  SC_uSeq_Stall_OutHigh,
  output logic                  SC_uSeq_Err_OutHigh,
  output logic [1:0]            SC_uSeq_State_Out
);

  typedef enum logic [1:0] {
    RST_S = 2'd0,
    RUN   = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] upc_q, upc_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] inc_addr;
  logic [ADDR_WIDTH-1:0] jmp_addr;
  logic [ADDR_WIDTH-1:0] dec_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  mem_op;
  logic                  bad_op;
  logic                  adv;
  logic                  mir_write;
  logic                  stall;

  assign inc_addr = upc_q + 1'b1;
  assign jmp_addr = SC_uSeq_JMPADDR_In;
  assign dec_addr = {1'b1, SC_uSeq_IROP_In, SC_uSeq_IROP3_In, 2'b00};
  assign mem_op   = SC_uSeq_RD_In | SC_uSeq_WR_In;
  assign bad_op   = SC_uSeq_RD_In & SC_uSeq_WR_In;

  // Flags and IR fields are used live; the branch resolves in the cycle it is executed.
  always_comb begin
    next_addr = inc_addr;
    case (SC_uSeq_COND_In)
      3'b000:  next_addr = inc_addr;
      3'b001:  next_addr = SC_uSeq_N_In    ? jmp_addr : inc_addr;
      3'b010:  next_addr = SC_uSeq_Z_In    ? jmp_addr : inc_addr;
      3'b011:  next_addr = SC_uSeq_V_In    ? jmp_addr : inc_addr;
      3'b100:  next_addr = SC_uSeq_C_In    ? jmp_addr : inc_addr;
      3'b101:  next_addr = SC_uSeq_IR13_In ? jmp_addr : inc_addr;
      3'b110:  next_addr = jmp_addr;
      default: next_addr = dec_addr;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    upc_d     = upc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    adv       = 1'b0;
    mir_write = 1'b0;
    case (state_q)
      RST_S: begin
        mir_write = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        if (bad_op) err_d = 1'b1;
        if (!mem_op || SC_uSeq_MemReady_InHigh) begin
          adv = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = 8'd1;
        end
      end
      WAIT: begin
        if (bad_op) err_d = 1'b1;
        if (SC_uSeq_MemReady_InHigh) begin
          adv = 1'b1;
        end else if (cnt_q == MEM_TIMEOUT) begin
          adv   = 1'b1;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = RST_S;
    endcase
    if (adv) begin
      upc_d     = next_addr;
      mir_write = 1'b1;
      state_d   = RUN;
    end
    // The advancing cycle itself is not a stall: the MIR reloads on it.
    stall = (state_q == RUN || state_q == WAIT) && !adv;
    if (!SC_uSeq_Reset_InLow) begin
      state_d   = RST_S;
      upc_d     = RESET_ADDR;
      cnt_d     = 8'd0;
      err_d     = 1'b0;
      mir_write = 1'b0;
      stall     = 1'b0;
    end
  end

  always_ff @(posedge SC_uSeq_CLOCK_50) begin
    state_q <= state_d;
    upc_q   <= upc_d;
    cnt_q   <= cnt_d;
    err_q   <= err_d;
  end

  assign SC_uSeq_CSAddr_Out       = SC_uSeq_Reset_InLow ? upc_q : RESET_ADDR;
  assign SC_uSeq_MIRWrite_OutHigh = mir_write;
  assign SC_uSeq_Stall_OutHigh    = stall;
  assign SC_uSeq_Err_OutHigh      = SC_uSeq_Reset_InLow &
                                    (err_q | (bad_op & (state_q != RST_S)));
  assign SC_uSeq_State_Out        = state_q;

endmodule

// File: tb/tb_sc_useq.sv
// Bench for sc_useq: directed sequences plus random microprogram traffic, checked
// every cycle against a cycle-level reference model through an expected-output queue.
module tb_sc_useq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cond;
  logic [10:0] jmp;
  logic        rd, wr;
  logic        n_f, z_f, v_f, c_f;
  logic [1:0]  irop;
  logic [5:0]  irop3;
  logic        ir13;
  logic        ready;
  logic [10:0] cs_addr;
  logic        mir_write, stall, err;
  logic [1:0]  state_dbg;

  logic [13:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          stall_run = 0;
  int          last_run = 0;

  // reference model state
  int          m_upc;
  bit          m_fresh;
  int          m_w;
  bit          m_err;
  bit          last_mw;

  sc_useq dut (
    .SC_uSeq_CLOCK_50         (clk),
    .SC_uSeq_Reset_InLow      (rst_n),
    .SC_uSeq_COND_In          (cond),
    .SC_uSeq_JMPADDR_In       (jmp),
    .SC_uSeq_RD_In            (rd),
    .SC_uSeq_WR_In            (wr),
    .SC_uSeq_N_In             (n_f),
    .SC_uSeq_Z_In             (z_f),
    .SC_uSeq_V_In             (v_f),
    .SC_uSeq_C_In             (c_f),
    .SC_uSeq_IROP_In          (irop),
    .SC_uSeq_IROP3_In         (irop3),
    .SC_uSeq_IR13_In          (ir13),
    .SC_uSeq_MemReady_InHigh  (ready),
    .SC_uSeq_CSAddr_Out       (cs_addr),
    .SC_uSeq_MIRWrite_OutHigh (mir_write),
    .SC_uSeq_Stall_OutHigh    (stall),
    .SC_uSeq_Err_OutHigh      (err),
    .SC_uSeq_State_Out        (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic int ref_next();
    int inc;
    int tgt;
    inc = (m_upc + 1) % 2048;
    tgt = int'(jmp);
    case (cond)
      3'd0: return inc;
      3'd1: return n_f  ? tgt : inc;
      3'd2: return z_f  ? tgt : inc;
      3'd3: return v_f  ? tgt : inc;
      3'd4: return c_f  ? tgt : inc;
      3'd5: return ir13 ? tgt : inc;
      3'd6: return tgt;
      default: return 1024 + int'(irop) * 256 + int'(irop3) * 4;
    endcase
  endfunction

  // Expected outputs for the current cycle, then advance the model one clock.
  task automatic step();
    logic [13:0] e;
    bit adv, errnow;
    int nx;
    if (!rst_n) begin
      e = 14'd0;
      m_upc = 0; m_fresh = 1; m_w = 0; m_err = 0; last_mw = 1;
    end else if (m_fresh) begin
      e = {11'(m_upc), 1'b1, 1'b0, m_err};
      m_fresh = 0; last_mw = 1;
    end else begin
      nx     = ref_next();
      errnow = m_err | (rd & wr);
      adv    = !(rd | wr) || ready || (m_w == 255);
      e      = {11'(m_upc), adv, !adv, errnow};
      m_err  = errnow | ((m_w == 255) && !ready);
      if (adv) begin
        m_upc = nx;
        m_w   = 0;
      end else begin
        m_w++;
      end
      last_mw = adv;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic mir(input logic [2:0] c, input logic [10:0] j, input logic r, input logic w);
    cond = c; jmp = j; rd = r; wr = w;
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    logic [13:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({cs_addr, mir_write, stall, err} !== e) begin
        failures++;
        $display("FAIL cycle_out @%0t: got addr=%h mw=%b st=%b err=%b expected addr=%h mw=%b st=%b err=%b",
                 $time, cs_addr, mir_write, stall, err, e[13:3], e[2], e[1], e[0]);
      end
      if (stall === 1'b1) begin
        stall_run++;
      end else if (stall_run > 0) begin
        last_run  = stall_run;
        stall_run = 0;
      end
    end
  end

  initial begin
    rst_n = 1'b0; ready = 1'b0;
    n_f = 0; z_f = 0; v_f = 0; c_f = 0; irop = 0; irop3 = 0; ir13 = 0;
    mir(3'd0, 11'd0, 1'b0, 1'b0);
    m_upc = 0; m_fresh = 1; m_w = 0; m_err = 0; last_mw = 1;
    @(posedge clk);
    #1;

    // reset and first fetch
    step(); step();
    rst_n = 1'b1;
    step(); step();

    // branches around uPC = 5
    mir(3'd6, 11'd5, 0, 0);     step();
    z_f = 1; mir(3'd2, 11'h40, 0, 0); step();
    mir(3'd6, 11'd5, 0, 0);     step();
    z_f = 0; mir(3'd2, 11'h40, 0, 0); step();
    n_f = 1; c_f = 1; mir(3'd6, 11'h40, 0, 0); step();
    ir13 = 1; mir(3'd5, 11'h40, 0, 0); step();
    irop = 2'b10; irop3 = 6'b010000; mir(3'd7, 11'd0, 0, 0); step();
    mir(3'd6, 11'd2047, 0, 0);  step();
    mir(3'd0, 11'd0, 0, 0);     step(); step();

    // memory wait of three low cycles, then ready
    mir(3'd0, 11'd0, 1, 0); ready = 0;
    repeat (3) step();
    ready = 1; step();
    ready = 0; mir(3'd0, 11'd0, 0, 0); step(); step();
    check_int("stall_len_wait3", last_run, 3);

    // timeout
    mir(3'd0, 11'd0, 1, 0); ready = 0;
    repeat (256) step();
    mir(3'd0, 11'd0, 0, 0); step(); step();
    check_int("stall_len_timeout", last_run, 255);

    // clear, then RD&WR error sticks
    rst_n = 0; step(); rst_n = 1; step(); step();
    ready = 1; mir(3'd0, 11'd0, 1, 1); step();
    ready = 0; mir(3'd0, 11'd0, 0, 0); repeat (3) step();

    // reset while waiting
    mir(3'd0, 11'd0, 1, 0); ready = 0; repeat (3) step();
    rst_n = 0; step();
    rst_n = 1; mir(3'd0, 11'd0, 0, 0); step(); step();

    // random microprogram traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst_n = ($urandom_range(0, 199) != 0);
      if (last_mw) begin
        r = $urandom_range(0, 9);
        mir(3'($urandom_range(0, 7)), 11'($urandom_range(0, 2047)),
            (r == 0 || r == 1), (r == 1 || r == 2));
      end
      {n_f, z_f, v_f, c_f, ir13} = 5'($urandom_range(0, 31));
      irop  = 2'($urandom_range(0, 3));
      irop3 = 6'($urandom_range(0, 63));
      ready = ($urandom_range(0, 3) == 0);
      step();
    end

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
